// File: rtl/ped_pkg.sv
// ped_pkg: state encoding and default 12 MHz timing for the pedestrian request front end.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVED  = 2'd2,
        HOLDOFF = 2'd3
    } ped_state_e;

    localparam int CLK_HZ_DEF  = 12_000_000;
    localparam int DEBOUNCE_MS = 20;
    localparam int HOLDOFF_MS  = 1000;
    localparam int BLINK_MS    = 250;
    localparam int TIMEOUT_MS  = 20_000;

    // Milliseconds to clock cycles; kHz-first ordering keeps 20 s at 12 MHz inside int range.
    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Width of a counter that runs 0 .. limit-1 (at least one bit).
    function automatic int cnt_width(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a stable-level debouncer.
// dout changes only after the synchronised input has differed from it for DEBOUNCE_CYC cycles.
module btn_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYC = ms_to_cyc(CLK_HZ_DEF, DEBOUNCE_MS)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/ped_request.sv
// ped_request: pedestrian push-button front end. Debounces the button, latches one
// crossing request with a req/ack handshake, drives the WAIT LED and enforces a
// hold-off after each walk phase.
// Optional feature macro: PED_REQ_TIMEOUT_EN (pending-age timeout with sticky err).
module ped_request
    import ped_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEF,
    parameter int DEBOUNCE_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS),
    parameter int HOLDOFF_CYC  = ms_to_cyc(CLK_HZ, HOLDOFF_MS),
    parameter int BLINK_CYC    = ms_to_cyc(CLK_HZ, BLINK_MS)
`ifdef PED_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC  = ms_to_cyc(CLK_HZ, TIMEOUT_MS)
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       ack,
    input  logic       walk_active,
    output logic       req,
    output logic       wait_led,
    output logic [7:0] press_cnt,
    output logic       err
);

    localparam int            HW        = cnt_width(HOLDOFF_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYC - 1);
    localparam int            BW        = cnt_width(BLINK_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    ped_state_e    state_q, state_d;
    logic          btn_db, btn_db_prev_q, press;
    logic [7:0]    press_cnt_q, press_cnt_d;
    logic          walk_seen_q, walk_seen_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic          req_q, req_d;
    logic          wait_led_q, wait_led_d;
    logic          timeout;   // PENDING timed out this cycle: drop req for one cycle
    logic          gap_q;     // the one-cycle req drop after a timeout

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_raw),
        .dout (btn_db)
    );

    assign press = btn_db & ~btn_db_prev_q;

`ifdef PED_REQ_TIMEOUT_EN
    localparam int            AW       = cnt_width(TIMEOUT_CYC);
    localparam logic [AW-1:0] AGE_LAST = AW'(TIMEOUT_CYC - 1);

    logic [AW-1:0] age_q, age_d;
    logic          err_q;

    assign timeout = (state_q == PENDING) && !gap_q && !ack && (age_q == AGE_LAST);

    // Pending age runs only on steady PENDING cycles and restarts after every timeout.
    always_comb begin
        age_d = '0;
        if ((state_q == PENDING) && !gap_q && !ack && (age_q != AGE_LAST)) begin
            age_d = age_q + 1'b1;
        end
    end

    // Age counter, req-drop cycle and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
            gap_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            age_q <= age_d;
            gap_q <= timeout;
            err_q <= err_q | timeout;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign gap_q   = 1'b0;
    assign err     = 1'b0;
`endif

    // Request FSM, press counter, hold-off timer, blink generator and registered outputs.
    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        walk_seen_d = 1'b0;
        hold_cnt_d  = '0;
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        req_d       = 1'b0;
        wait_led_d  = 1'b0;

        if (press && (press_cnt_q != 8'hFF)) begin
            press_cnt_d = press_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (press && !walk_active) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (ack) begin
                    state_d = SERVED;
                end
            end
            SERVED: begin
                // Leave only on a fall of a walk phase actually observed here.
                walk_seen_d = walk_seen_q | walk_active;
                if (walk_seen_q && !walk_active) begin
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Blink advances on steady PENDING cycles; entry and re-entry restart it at phase 0.
        if ((state_q == PENDING) && (state_d == PENDING) && !gap_q && !timeout) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_ph_d = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_ph_d  = blink_ph_q;
            end
        end

        if (state_d == PENDING) begin
            req_d      = !timeout;
            wait_led_d = !timeout && !blink_ph_d;
        end else begin
            wait_led_d = (state_d == SERVED);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            btn_db_prev_q <= 1'b0;
            press_cnt_q   <= 8'd0;
            walk_seen_q   <= 1'b0;
            hold_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_ph_q    <= 1'b0;
            req_q         <= 1'b0;
            wait_led_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_db_prev_q <= btn_db;
            press_cnt_q   <= press_cnt_d;
            walk_seen_q   <= walk_seen_d;
            hold_cnt_q    <= hold_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_ph_q    <= blink_ph_d;
            req_q         <= req_d;
            wait_led_q    <= wait_led_d;
        end
    end

    assign req       = req_q;
    assign wait_led  = wait_led_q;
    assign press_cnt = press_cnt_q;

endmodule
